// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the alu and its accumulator sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit alu: carr is the carry/borrow out for ADD/SUB, the shifted-out bit for
// shifts, and 0 for logic ops; zero flags an all-zero result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic             carr,
  output logic             zero
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      OP_XOR:  ext = {1'b0, a ^ b};
      OP_NOT:  ext = {1'b0, ~a};
      OP_SHL:  ext = {a, 1'b0};
      OP_SHR:  ext = {a[0], 1'b0, a[WIDTH-1:1]};
      default: ext = '0;
    endcase
  end

  assign result = ext[WIDTH-1:0];
  assign carr   = ext[WIDTH];
  assign zero   = (ext[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_seq_stats.sv
// Saturating count of completed response handshakes; built only with ALU_SEQ_STATS_EN.
module alu_seq_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_accum_seq.sv
// Accumulator sequencer feeding an external alu; ALU ops respond 2 cycles after accept, loads 1.
// Optional macro ALU_SEQ_STATS_EN builds the saturating response counter behind op_count.
module alu_accum_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_load,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carr,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             zflag;
  logic             accept;

  // Accepting in RESP while the response drains keeps one ALU command per 2 cycles.
  assign in_ready = (state == S_IDLE) || ((state == S_RESP) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      zflag     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_EXEC: begin
          acc       <= alu_result;
          carry     <= alu_carr;
          zflag     <= alu_zero;
          out_valid <= 1'b1;
          state     <= S_RESP;
        end
        default: begin
          if (state == S_RESP && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
          if (accept) begin
            if (in_load) begin
              acc       <= in_imm;
              carry     <= 1'b0;
              zflag     <= (in_imm == '0);
              out_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              alu_a     <= acc;
              alu_b     <= in_imm;
              alu_op    <= in_op;
              out_valid <= 1'b0;
              state     <= S_EXEC;
            end
          end
        end
      endcase
    end
  end

  assign out_acc   = acc;
  assign out_carry = carry;
  assign out_zero  = zflag;

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid && out_ready),
    .count(op_count)
  );
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench: sequencer plus the real alu, hand-computed expectations checked by assertions.
module tb_alu_accum_seq;
  import alu_pkg::*;

  localparam int WIDTH = 4;
  localparam int OPW   = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_op;
  logic [WIDTH-1:0] in_imm;
  logic             in_load;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carr;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_acc;
  logic             out_carry;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_accum_seq #(.WIDTH(WIDTH), .OPW(OPW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_load   (in_load),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .alu_carr  (alu_carr),
    .alu_zero  (alu_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .op_count  (op_count)
  );

  alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .result(alu_result),
    .carr  (alu_carr),
    .zero  (alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the command until accepted; returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic ld, input logic [OPW-1:0] op, input logic [WIDTH-1:0] imm);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_load  = ld;
    in_op    = op;
    in_imm   = imm;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_within_budget", 32'(n < 20), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  logic [OPW-1:0]   t_op  [3];
  logic [WIDTH-1:0] t_imm [3];
  logic [WIDTH-1:0] t_acc [3];
  logic             t_cy  [3];

  initial begin
    t_op  = '{OP_SUB, OP_XOR, OP_SHL};
    t_imm = '{4'hA, 4'h5, 4'h0};
    t_acc = '{4'hF, 4'hA, 4'h4};
    t_cy  = '{1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = '0; in_imm = '0; out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_acc", 32'(out_acc), 0);
    chk("rst_carry", 32'(out_carry), 0);
    chk("rst_zero", 32'(out_zero), 0);
    chk("rst_op_count", 32'(op_count), 0);

    // 1: load 3 then ADD 5
    send(1'b1, OP_ADD, 4'h3);
    chk("t1_load_lat1_valid", 32'(out_valid), 1);
    chk("t1_load_acc", 32'(out_acc), 3);
    step();
    send(1'b0, OP_ADD, 4'h5);
    chk("t1_add_exec_valid", 32'(out_valid), 0);
    chk("t1_alu_a", 32'(alu_a), 3);
    chk("t1_alu_b", 32'(alu_b), 5);
    chk("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
    step();
    chk("t1_add_lat2_valid", 32'(out_valid), 1);
    chk("t1_add_acc", 32'(out_acc), 8);
    chk("t1_add_zero", 32'(out_zero), 0);
    chk("t1_add_carry", 32'(out_carry), 0);
    step();

    // 2: load 0 then ADD 0
    send(1'b1, OP_ADD, 4'h0);
    chk("t2_load_lat1_valid", 32'(out_valid), 1);
    chk("t2_load_zero", 32'(out_zero), 1);
    step();
    send(1'b0, OP_ADD, 4'h0);
    step();
    chk("t2_add_valid", 32'(out_valid), 1);
    chk("t2_add_acc", 32'(out_acc), 0);
    chk("t2_add_zero", 32'(out_zero), 1);
    step();

    // 3: load F then ADD 1 wraps with carry
    send(1'b1, OP_ADD, 4'hF);
    chk("t3_load_acc", 32'(out_acc), 15);
    step();
    send(1'b0, OP_ADD, 4'h1);
    step();
    chk("t3_add_acc", 32'(out_acc), 0);
    chk("t3_add_carry", 32'(out_carry), 1);
    chk("t3_add_zero", 32'(out_zero), 1);
    step();

    // 4: response stalled 5 cycles while a new load waits upstream
    out_ready = 1'b0;
    send(1'b1, OP_ADD, 4'h6);
    in_valid = 1'b1; in_load = 1'b1; in_imm = 4'h9;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_valid", 32'(out_valid), 1);
      chk("t4_stall_acc", 32'(out_acc), 6);
      chk("t4_stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4_next_load_valid", 32'(out_valid), 1);
    chk("t4_next_load_acc", 32'(out_acc), 9);

    // 5: back-to-back SUB/XOR/SHL from acc=9, drained at full rate
    in_valid = 1'b1; in_load = 1'b0; in_op = t_op[0]; in_imm = t_imm[0];
    for (int i = 0; i < 3; i++) begin
      chk("t5_rdy_in_resp", 32'(in_ready), 1);
      step();
      chk("t5_busy_in_exec", 32'(in_ready), 0);
      chk("t5_exec_no_valid", 32'(out_valid), 0);
      chk("t5_alu_op", 32'(alu_op), 32'(t_op[i]));
      if (i < 2) begin
        in_op = t_op[i+1]; in_imm = t_imm[i+1];
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("t5_resp_valid", 32'(out_valid), 1);
      chk("t5_resp_acc", 32'(out_acc), 32'(t_acc[i]));
      chk("t5_resp_carry", 32'(out_carry), 32'(t_cy[i]));
      chk("t5_resp_zero", 32'(out_zero), 0);
    end
    step();
    chk("t5_drained_idle", 32'(in_ready), 1);

    // 6: reset mid-EXEC, then 3 handshakes
    send(1'b0, OP_ADD, 4'h3);
    chk("t6_in_exec", 32'(in_ready), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_acc", 32'(out_acc), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    chk("t6_rst_op_count", 32'(op_count), 0);
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, OP_ADD, 4'(i));
      step();
    end
    chk("t6_final_acc", 32'(out_acc), 3);
`ifdef ALU_SEQ_STATS_EN
    chk("t6_op_count", 32'(op_count), 3);
`else
    chk("t6_op_count_tied", 32'(op_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
